// File: rtl/pipe_chain_ctrl_pkg.sv
// Shared types and helpers for the elastic register chain controller.
package pipe_chain_ctrl_pkg;

    localparam int unsigned StageWidth = 4;

    typedef struct packed {
        logic                  valid;
        logic [StageWidth-1:0] data;
    } stage_t;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One clock-enabled stage of the chain: a valid bit plus a data register.
module pipe_slot #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             en,
    input  logic             flush,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            v <= 1'b0;
            d <= '0;
        end else if (flush) begin
            v <= 1'b0;
        end else if (en) begin
            v <= src_valid;
            // Bubbles do not disturb the held data.
            if (src_valid) begin
                d <= src_data;
            end
        end
    end

endmodule

// File: rtl/pipe_chain_ctrl.sv
// Elastic controller for a DEPTH-stage register chain with ready/valid on both ends,
// bubble collapsing under backpressure and a synchronous flush.
module pipe_chain_ctrl
    import pipe_chain_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           CLK,
    input  logic                           ASYNCRESETN,
    input  logic                           I_valid,
    output logic                           I_ready,
    input  logic [WIDTH-1:0]               I,
    output logic                           O_valid,
    input  logic                           O_ready,
    output logic [WIDTH-1:0]               O,
    input  logic                           flush,
    output logic [DEPTH-1:0]               stage_en,
    output logic [cnt_width(DEPTH)-1:0]    count
);

    localparam int unsigned CntW = cnt_width(DEPTH);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] d     [DEPTH];
    logic [WIDTH-1:0] src_d [DEPTH];
    logic [DEPTH-1:0] en_raw;
    logic             in_xfer;
    logic             out_xfer;
    logic [CntW-1:0]  count_q;
    logic [CntW-1:0]  count_d;

    assign src_v = {v[DEPTH-2:0], I_valid};

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        if (k == 0) begin : g_head
            assign src_d[k] = I;
        end else begin : g_body
            assign src_d[k] = d[k-1];
        end

        pipe_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .CLK        (CLK),
            .ASYNCRESETN(ASYNCRESETN),
            .en         (stage_en[k]),
            .flush      (flush),
            .src_valid  (src_v[k]),
            .src_data   (src_d[k]),
            .v          (v[k]),
            .d          (d[k])
        );
    end

    // A stage may load when it or any stage after it is empty, or the consumer drains.
    always_comb begin
        logic full_run;
        full_run = 1'b1;
        en_raw   = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            full_run  = full_run & v[k];
            en_raw[k] = !full_run || O_ready;
        end
        stage_en = flush ? '0 : en_raw;
    end

    assign I_ready  = stage_en[0];
    assign O_valid  = v[DEPTH-1] && !flush;
    assign O        = d[DEPTH-1];
    assign in_xfer  = I_valid && I_ready;
    assign out_xfer = O_valid && O_ready;

    always_comb begin
        count_d = count_q;
        unique case ({in_xfer, out_xfer})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            count_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_pipe_chain_ctrl.sv
// Randomized and directed bench; a queue of in-flight items predicts when each becomes visible.
module tb_pipe_chain_ctrl;
    import pipe_chain_ctrl_pkg::*;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = cnt_width(DEPTH);

    logic             CLK = 1'b0;
    logic             ASYNCRESETN;
    logic             I_valid;
    logic             I_ready;
    logic [WIDTH-1:0] I;
    logic             O_valid;
    logic             O_ready;
    logic [WIDTH-1:0] O;
    logic             flush;
    logic [DEPTH-1:0] stage_en;
    logic [CW-1:0]    count;

    pipe_chain_ctrl #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .CLK        (CLK),
        .ASYNCRESETN(ASYNCRESETN),
        .I_valid    (I_valid),
        .I_ready    (I_ready),
        .I          (I),
        .O_valid    (O_valid),
        .O_ready    (O_ready),
        .O          (O),
        .flush      (flush),
        .stage_en   (stage_en),
        .count      (count)
    );

    always #5 CLK = ~CLK;

    // Item in flight: its data and the first cycle it may appear at the output.
    typedef struct {
        logic [WIDTH-1:0] data;
        int               vis;
    } item_t;

    item_t q[$];
    int    cyc     = 0;
    int    n_check = 0;
    int    n_bad   = 0;
    int    first_out;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_check++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive, check against the model mid-cycle, advance the model at the edge.
    task automatic step(input logic iv, input logic [WIDTH-1:0] id, input logic ordy,
                        input logic fl);
        logic  front_vis;
        logic  exp_ov;
        logic  exp_ir;
        item_t tmp;
        I_valid = iv;
        I       = id;
        O_ready = ordy;
        flush   = fl;
        #3;
        front_vis = (q.size() > 0) && (cyc >= q[0].vis);
        exp_ov    = !fl && front_vis;
        exp_ir    = !fl && ((q.size() < DEPTH) || ordy);
        check_eq("o_valid", int'(O_valid), int'(exp_ov));
        if (exp_ov) check_eq("o_data", int'(O), int'(q[0].data));
        check_eq("i_ready", int'(I_ready), int'(exp_ir));
        check_eq("count", int'(count), q.size());
        check_eq("en_first", int'(stage_en[0]), int'(exp_ir));
        check_eq("en_last", int'(stage_en[DEPTH-1]), int'(!fl && (!front_vis || ordy)));
        if (exp_ov && first_out < 0) first_out = cyc;
        @(posedge CLK);
        if (fl) begin
            q.delete();
        end else begin
            if (exp_ov && ordy) begin
                void'(q.pop_front());
                // The next item sits right behind and moves up on the departure edge.
                if (q.size() > 0 && q[0].vis < cyc + 1) begin
                    tmp     = q[0];
                    tmp.vis = cyc + 1;
                    q[0]    = tmp;
                end
            end
            if (iv && exp_ir) q.push_back('{data: id, vis: cyc + int'(DEPTH)});
        end
        cyc++;
        #1;
    endtask

    initial begin
        int t0;
        ASYNCRESETN = 1'b0;
        I_valid     = 1'b0;
        I           = '0;
        O_ready     = 1'b0;
        flush       = 1'b0;
        first_out   = -1;
        repeat (2) @(posedge CLK);
        #1;
        check_eq("rst_o_valid", int'(O_valid), 0);
        check_eq("rst_o", int'(O), 0);
        check_eq("rst_count", int'(count), 0);
        check_eq("rst_i_ready", int'(I_ready), 1);
        check_eq("rst_en", int'(stage_en), (1 << DEPTH) - 1);
        #3 ASYNCRESETN = 1'b1;
        @(posedge CLK);
        #1;

        // Stream 1..8 with the consumer always ready.
        t0 = cyc;
        for (int i = 1; i <= 8; i++) step(1'b1, WIDTH'(i), 1'b1, 1'b0);
        check_eq("stream_latency", first_out - t0, 4);
        check_eq("stream_count", int'(count), 4);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Backpressure until full, then simultaneous in/out.
        step(1'b1, 4'hA, 1'b0, 1'b0);
        step(1'b1, 4'hB, 1'b0, 1'b0);
        step(1'b1, 4'hC, 1'b0, 1'b0);
        step(1'b1, 4'hD, 1'b0, 1'b0);
        step(1'b1, 4'hE, 1'b0, 1'b0);
        check_eq("full_count", int'(count), 4);
        step(1'b1, 4'hE, 1'b1, 1'b0);
        check_eq("swap_count", int'(count), 4);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Bubble collapse behind a stalled head.
        step(1'b1, 4'h3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 4'h5, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
        check_eq("collapse_count", int'(count), 2);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Flush a full chain.
        for (int i = 0; i < 4; i++) step(1'b1, WIDTH'(i + 6), 1'b0, 1'b0);
        step(1'b1, 4'h1, 1'b1, 1'b1);
        check_eq("flush_count", int'(count), 0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset between edges with three items held.
        for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(i + 2), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        #1 ASYNCRESETN = 1'b0;
        #1;
        check_eq("arst_o_valid", int'(O_valid), 0);
        check_eq("arst_o", int'(O), 0);
        check_eq("arst_count", int'(count), 0);
        check_eq("arst_i_ready", int'(I_ready), 1);
        q.delete();
        #2 ASYNCRESETN = 1'b1;
        @(posedge CLK);
        cyc++;
        #1;
        first_out = -1;
        t0        = cyc;
        step(1'b1, 4'h9, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
        check_eq("arst_latency", first_out - t0, 4);

        // Random traffic, with occasional flushes.
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));
            check_eq("cnt_bound", int'(count <= DEPTH), 1);
        end
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
        check_eq("drained", int'(count), 0);

        $display("test done: total=%0d bad=%0d", n_check, n_bad);
        $finish;
    end

endmodule
